// File: rtl/fir_phase_scheduler.sv
// -----------------------------------------------------------------------------
// fir_phase_scheduler
//
// Shares one FIR datapath between three phase channels (A/B/C) that feed the
// sequence decomposer. Each accepted sample set is sent to the FIR as A, B and
// C on three consecutive cycles, each with a channel tag. A tag pipe matching
// the FIR latency routes every returning result to its phase. All three results
// are presented together with a one-cycle out_valid pulse.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  sample-set handshake (in_ready high only in IDLE)
//   xa, xb, xc          phase samples, unsigned, XW bits
//   fir_en/ch/x         registered issue strobe, channel tag, sample to FIR
//   fir_y               FIR result, FIR_LAT edges after its issue edge
//   ya, yb, yc          per-phase results, held until the next completed set
//   out_valid           one-cycle pulse when ya/yb/yc update
//   overrun             sticky: in_valid seen while in_ready was low
//   ovr_cnt             (FIR_SCHED_OVR_CNT_EN only) saturating rejected count
//
// Configuration macro: FIR_SCHED_OVR_CNT_EN
//   defined   -> ovr_cnt[7:0] port present, overrun = (ovr_cnt != 0)
//   undefined -> no ovr_cnt port, overrun is a plain sticky flag
// -----------------------------------------------------------------------------
module fir_phase_scheduler #(
  parameter int FIR_LAT = 2,
  parameter int XW      = 8,
  parameter int YW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] xa,
  input  logic [XW-1:0] xb,
  input  logic [XW-1:0] xc,
  output logic          fir_en,
  output logic [1:0]    fir_ch,
  output logic [XW-1:0] fir_x,
  input  logic [YW-1:0] fir_y,
  output logic [YW-1:0] ya,
  output logic [YW-1:0] yb,
  output logic [YW-1:0] yc,
  output logic          out_valid,
`ifdef FIR_SCHED_OVR_CNT_EN
  output logic [7:0]    ovr_cnt,
`endif
  output logic          overrun
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_A = 3'd1,
    ISSUE_B = 3'd2,
    ISSUE_C = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [XW-1:0]              xb_q, xb_d, xc_q, xc_d;
  logic                       fir_en_q, fir_en_d;
  logic [1:0]                 fir_ch_q, fir_ch_d;
  logic [XW-1:0]              fir_x_q, fir_x_d;
  logic [FIR_LAT-1:0]         tag_vld_q, tag_vld_d;
  logic [FIR_LAT-1:0][1:0]    tag_ch_q, tag_ch_d;
  logic [YW-1:0]              ya_sh_q, ya_sh_d, yb_sh_q, yb_sh_d;
  logic [YW-1:0]              ya_q, ya_d, yb_q, yb_d, yc_q, yc_d;
  logic                       out_valid_q, out_valid_d;
  logic                       cap_vld, cap_c, reject;
  logic [1:0]                 cap_ch;

  assign in_ready = (state_q == IDLE);
  assign reject   = in_valid & ~in_ready;

  // The oldest tag lines up with fir_y at this edge.
  assign cap_vld = tag_vld_q[FIR_LAT-1];
  assign cap_ch  = tag_ch_q[FIR_LAT-1];
  assign cap_c   = cap_vld && (cap_ch == 2'd2);

  // Issue FSM. fir_* are registered, so each state computes the issue for the
  // following cycle; phase A is taken straight from the inputs on accept.
  always_comb begin
    state_d  = state_q;
    xb_d     = xb_q;
    xc_d     = xc_q;
    fir_en_d = 1'b0;
    fir_ch_d = 2'd0;
    fir_x_d  = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = ISSUE_A;
          xb_d     = xb;
          xc_d     = xc;
          fir_en_d = 1'b1;
          fir_ch_d = 2'd0;
          fir_x_d  = xa;
        end
      end
      ISSUE_A: begin
        state_d  = ISSUE_B;
        fir_en_d = 1'b1;
        fir_ch_d = 2'd1;
        fir_x_d  = xb_q;
      end
      ISSUE_B: begin
        state_d  = ISSUE_C;
        fir_en_d = 1'b1;
        fir_ch_d = 2'd2;
        fir_x_d  = xc_q;
      end
      ISSUE_C: state_d = DRAIN;
      DRAIN:   if (cap_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tag pipe: mirrors the FIR pipeline, one stage per FIR register.
  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_ch_d     = tag_ch_q;
    tag_vld_d[0] = fir_en_q;
    tag_ch_d[0]  = fir_ch_q;
    for (int i = 1; i < FIR_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_ch_d[i]  = tag_ch_q[i-1];
    end
  end

  // Result capture: A/B park in shadow registers so the outputs change only
  // once, together, on the C capture edge.
  always_comb begin
    ya_sh_d     = ya_sh_q;
    yb_sh_d     = yb_sh_q;
    ya_d        = ya_q;
    yb_d        = yb_q;
    yc_d        = yc_q;
    out_valid_d = cap_c;
    if (cap_vld) begin
      case (cap_ch)
        2'd0:    ya_sh_d = fir_y;
        2'd1:    yb_sh_d = fir_y;
        2'd2: begin
          ya_d = ya_sh_q;
          yb_d = yb_sh_q;
          yc_d = fir_y;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      xb_q        <= '0;
      xc_q        <= '0;
      fir_en_q    <= 1'b0;
      fir_ch_q    <= 2'd0;
      fir_x_q     <= '0;
      tag_vld_q   <= '0;
      tag_ch_q    <= '0;
      ya_sh_q     <= '0;
      yb_sh_q     <= '0;
      ya_q        <= '0;
      yb_q        <= '0;
      yc_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      xb_q        <= xb_d;
      xc_q        <= xc_d;
      fir_en_q    <= fir_en_d;
      fir_ch_q    <= fir_ch_d;
      fir_x_q     <= fir_x_d;
      tag_vld_q   <= tag_vld_d;
      tag_ch_q    <= tag_ch_d;
      ya_sh_q     <= ya_sh_d;
      yb_sh_q     <= yb_sh_d;
      ya_q        <= ya_d;
      yb_q        <= yb_d;
      yc_q        <= yc_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef FIR_SCHED_OVR_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (reject && (ovr_cnt_q != 8'hFF)) ovr_cnt_d = ovr_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_cnt_q <= 8'd0;
    else        ovr_cnt_q <= ovr_cnt_d;
  end

  assign ovr_cnt = ovr_cnt_q;
  assign overrun = (ovr_cnt_q != 8'd0);
`else
  logic overrun_q, overrun_d;

  assign overrun_d = overrun_q | reject;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`endif

  assign fir_en    = fir_en_q;
  assign fir_ch    = fir_ch_q;
  assign fir_x     = fir_x_q;
  assign ya        = ya_q;
  assign yb        = yb_q;
  assign yc        = yc_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fir_phase_scheduler
//
// Bench for fir_phase_scheduler at FIR_LAT=2 with a two-register FIR model
// (fir_y = 16*x + ch). Table-driven single sets plus hand-written sequences
// for back-to-back operation, overrun and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_fir_phase_scheduler;

  localparam int FIR_LAT = 2;
  localparam int XW      = 8;
  localparam int YW      = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XW-1:0] xa = '0, xb = '0, xc = '0;
  logic          fir_en;
  logic [1:0]    fir_ch;
  logic [XW-1:0] fir_x;
  logic [YW-1:0] fir_y;
  logic [YW-1:0] ya, yb, yc;
  logic          out_valid;
  logic          overrun;
`ifdef FIR_SCHED_OVR_CNT_EN
  logic [7:0]    ovr_cnt;
`endif

  fir_phase_scheduler #(.FIR_LAT(FIR_LAT), .XW(XW), .YW(YW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xa        (xa),
    .xb        (xb),
    .xc        (xc),
    .fir_en    (fir_en),
    .fir_ch    (fir_ch),
    .fir_x     (fir_x),
    .fir_y     (fir_y),
    .ya        (ya),
    .yb        (yb),
    .yc        (yc),
    .out_valid (out_valid),
`ifdef FIR_SCHED_OVR_CNT_EN
    .ovr_cnt   (ovr_cnt),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // FIR model: two registers, result appears two edges after the issue edge.
  logic [YW-1:0] fir_r1, fir_r2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fir_r1 <= '0;
      fir_r2 <= '0;
    end else begin
      fir_r1 <= fir_en ? (16'(fir_x) * 16'd16 + 16'(fir_ch)) : '0;
      fir_r2 <= fir_r1;
    end
  end
  assign fir_y = fir_r2;

  typedef struct {
    logic [XW-1:0] xa, xb, xc;
    logic [YW-1:0] ea, eb, ec;
  } vec_t;

  int pass_cnt = 0;
  int total    = 0;
  logic [YW-1:0] prev_a = '0, prev_b = '0, prev_c = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Runs one set from IDLE; optionally pulses in_valid (with junk data) while
  // the set is in flight.
  task automatic run_set(input vec_t v, input bit inject);
    int edges;
    logic [XW-1:0] xs [3];
    xs[0] = v.xa; xs[1] = v.xb; xs[2] = v.xc;
    @(negedge clk);
    edges = 0;
    while (!in_ready && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    chk("in_ready_before_set", 32'(in_ready), 32'd1);
    in_valid = 1'b1; xa = v.xa; xb = v.xb; xc = v.xc;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("issue_en", 32'(fir_en), 32'd1);
      chk("issue_ch", 32'(fir_ch), 32'(k));
      chk("issue_x", 32'(fir_x), 32'(xs[k]));
      if (inject && k == 1) begin
        in_valid = 1'b1; xa = 8'd99; xb = 8'd99; xc = 8'd99;
      end
      if (inject && k == 2) in_valid = 1'b0;
      @(negedge clk);
    end
    edges = 3;
    while (!out_valid && edges < 12) begin
      chk("no_partial_ya", 32'(ya), 32'(prev_a));
      chk("no_partial_yb", 32'(yb), 32'(prev_b));
      @(negedge clk);
      edges++;
    end
    chk("latency", 32'(edges), 32'(3 + FIR_LAT));
    chk("ya", 32'(ya), 32'(v.ea));
    chk("yb", 32'(yb), 32'(v.eb));
    chk("yc", 32'(yc), 32'(v.ec));
    prev_a = v.ea; prev_b = v.eb; prev_c = v.ec;
    @(negedge clk);
    chk("out_valid_one_cycle", 32'(out_valid), 32'd0);
    chk("ya_hold", 32'(ya), 32'(v.ea));
    if (inject) chk("overrun_sticky", 32'(overrun), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    vec_t v;
    int   pulses, first_cyc, extra;

    tbl[0] = '{xa: 8'd5,   xb: 8'd10, xc: 8'd12,  ea: 16'd80,   eb: 16'd161, ec: 16'd194};
    tbl[1] = '{xa: 8'd1,   xb: 8'd2,  xc: 8'd3,   ea: 16'd16,   eb: 16'd33,  ec: 16'd50};
    tbl[2] = '{xa: 8'd4,   xb: 8'd5,  xc: 8'd6,   ea: 16'd64,   eb: 16'd81,  ec: 16'd98};
    tbl[3] = '{xa: 8'd7,   xb: 8'd8,  xc: 8'd9,   ea: 16'd112,  eb: 16'd129, ec: 16'd146};
    tbl[4] = '{xa: 8'd255, xb: 8'd0,  xc: 8'd128, ea: 16'd4080, eb: 16'd1,   ec: 16'd2050};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_fir_en", 32'(fir_en), 32'd0);
    chk("rst_fir_ch", 32'(fir_ch), 32'd0);
    chk("rst_fir_x", 32'(fir_x), 32'd0);
    chk("rst_ya", 32'(ya), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_release", 32'(in_ready), 32'd1);
    chk("idle_fir_en", 32'(fir_en), 32'd0);

    // Single sets from the table
    for (int i = 0; i < 5; i++) run_set(tbl[i], 1'b0);
    chk("no_overrun_after_table", 32'(overrun), 32'd0);

    // Back-to-back with in_valid held high
    @(negedge clk);
    in_valid = 1'b1; xa = 8'd1; xb = 8'd2; xc = 8'd3;
    pulses = 0; first_cyc = 0;
    for (int cyc = 0; cyc < 30 && pulses < 2; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        pulses++;
        if (pulses == 1) begin
          chk("b2b_ya1", 32'(ya), 32'd16);
          chk("b2b_yb1", 32'(yb), 32'd33);
          chk("b2b_yc1", 32'(yc), 32'd50);
          chk("b2b_in_ready", 32'(in_ready), 32'd1);
          first_cyc = cyc;
          xa = 8'd4; xb = 8'd5; xc = 8'd6;
        end else begin
          chk("b2b_ya2", 32'(ya), 32'd64);
          chk("b2b_yb2", 32'(yb), 32'd81);
          chk("b2b_yc2", 32'(yc), 32'd98);
          chk("b2b_gap", 32'(cyc - first_cyc), 32'(3 + FIR_LAT + 1));
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd2);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("b2b_no_extra_pulse", 32'(extra), 32'd0);
    chk("b2b_overrun", 32'(overrun), 32'd1);
    prev_a = 16'd64; prev_b = 16'd81; prev_c = 16'd98;

    // Reset mid-operation (during ISSUE_B)
    @(negedge clk);
    in_valid = 1'b1; xa = 8'd1; xb = 8'd2; xc = 8'd3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_in_issue_b", 32'(fir_ch), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ya", 32'(ya), 32'd0);
    chk("midrst_yb", 32'(yb), 32'd0);
    chk("midrst_yc", 32'(yc), 32'd0);
    chk("midrst_fir_en", 32'(fir_en), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("midrst_no_out_valid", 32'(extra), 32'd0);
    prev_a = '0; prev_b = '0; prev_c = '0;
    run_set(tbl[3], 1'b0);

    // Overrun: in_valid pulse while busy, set completes unchanged
    chk("overrun_clear_before", 32'(overrun), 32'd0);
    v = '{xa: 8'd7, xb: 8'd8, xc: 8'd9, ea: 16'd112, eb: 16'd129, ec: 16'd146};
    run_set(v, 1'b1);
    repeat (6) @(negedge clk);
    chk("overrun_still_set", 32'(overrun), 32'd1);

`ifdef FIR_SCHED_OVR_CNT_EN
    // Saturating rejected-cycle counter
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("ovr_cnt_reset", 32'(ovr_cnt), 32'd0);
    in_valid = 1'b1;
    repeat (450) @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("ovr_cnt_sat", 32'(ovr_cnt), 32'd255);
    chk("ovr_cnt_overrun", 32'(overrun), 32'd1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
